// File: rtl/qupls_regfile_write_arbiter_if.sv
// Writeback bus bundle between the functional-unit result buses and the
// register file write arbiter, including the RAM port A side.
interface qupls_regfile_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int WID  = 65,
  parameter int DEP  = 512
);
  localparam int RBIT = $clog2(DEP) - 1;

  logic [NREQ-1:0]           req_i;
  logic [NREQ-1:0][RBIT:0]   addr_i;
  logic [NREQ-1:0][WID-1:0]  data_i;
  logic [NREQ-1:0]           ack_o;
  logic                      ena_o;
  logic                      wea_o;
  logic [RBIT:0]             addra_o;
  logic [WID-1:0]            dina_o;
  logic [RBIT:0]             wr_tag_o;
  logic                      wr_tag_v_o;
  logic                      init_done_o;

  modport master (
    output req_i, addr_i, data_i,
    input  ack_o, ena_o, wea_o, addra_o, dina_o, wr_tag_o, wr_tag_v_o, init_done_o
  );

  modport slave (
    input  req_i, addr_i, data_i,
    output ack_o, ena_o, wea_o, addra_o, dina_o, wr_tag_o, wr_tag_v_o, init_done_o
  );
endinterface

// File: rtl/qupls_regfile_write_arbiter.sv
// Round-robin arbiter sharing one register file RAM write port among NREQ
// writeback buses; zero-fills every physical register after reset.
//
// state | meaning
// INIT  | zero-fill sweep of addresses 0..DEP-1, no grants
// RUN   | round-robin arbitration, one registered write per cycle
module qupls_regfile_write_arbiter #(
  parameter int NREQ = 4,
  parameter int WID  = 65,
  parameter int DEP  = 512
) (
  input  logic                             clk,
  input  logic                             rst,
  qupls_regfile_write_arbiter_if.slave     wb
);
  localparam int RBIT = $clog2(DEP) - 1;
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [RBIT:0] CNT_LAST = (RBIT+1)'(DEP - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state;
  logic [RBIT:0]   cnt;
  logic [PW-1:0]   ptr;
  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   ptr_nxt;
  logic [PW-1:0]   idx;
  int              idx_i;

  // First asserted request at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    ptr_nxt = ptr;
    idx     = '0;
    idx_i   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx_i = int'(ptr) + i;
      if (idx_i >= NREQ) idx_i = idx_i - NREQ;
      idx = PW'(idx_i);
      if (!found && wb.req_i[idx]) begin
        found   = 1'b1;
        win     = idx;
        ptr_nxt = (idx_i == NREQ - 1) ? '0 : PW'(idx_i + 1);
      end
    end
  end

  assign wb.ack_o = (state == RUN && found) ? (NREQ'(1) << win) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= INIT;
      cnt            <= '0;
      ptr            <= '0;
      wb.ena_o       <= 1'b0;
      wb.wea_o       <= 1'b0;
      wb.addra_o     <= '0;
      wb.dina_o      <= '0;
      wb.wr_tag_o    <= '0;
      wb.wr_tag_v_o  <= 1'b0;
      wb.init_done_o <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          wb.ena_o      <= 1'b1;
          wb.wea_o      <= 1'b1;
          wb.addra_o    <= cnt;
          wb.dina_o     <= '0;
          wb.wr_tag_v_o <= 1'b0;
          if (cnt == CNT_LAST) begin
            state          <= RUN;
            wb.init_done_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (found) begin
            ptr           <= ptr_nxt;
            wb.addra_o    <= wb.addr_i[win];
            wb.dina_o     <= wb.data_i[win];
            wb.wr_tag_o   <= wb.addr_i[win];
            // Register 0 is hardwired zero: acked, but never written.
            wb.ena_o      <= (wb.addr_i[win] != '0);
            wb.wea_o      <= (wb.addr_i[win] != '0);
            wb.wr_tag_v_o <= (wb.addr_i[win] != '0);
          end else begin
            wb.ena_o      <= 1'b0;
            wb.wea_o      <= 1'b0;
            wb.wr_tag_v_o <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_qupls_regfile_write_arbiter.sv
// Self-checking bench for qupls_regfile_write_arbiter: zero-fill, round-robin
// order, address-0 suppression, random traffic with fairness, mid-run reset.
module tb_qupls_regfile_write_arbiter;
  localparam int NREQ = 4;
  localparam int WID  = 17;
  localparam int DEP  = 8;
  localparam int AW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  qupls_regfile_write_arbiter_if #(.NREQ(NREQ), .WID(WID), .DEP(DEP)) wb ();

  qupls_regfile_write_arbiter #(.NREQ(NREQ), .WID(WID), .DEP(DEP)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  typedef struct {
    logic           en;
    logic [AW-1:0]  a;
    logic [WID-1:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t em;

  // Each pushed entry describes the registered port-A state after the next edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      em = sb.pop_front();
      total++;
      if (wb.ena_o !== em.en || wb.wea_o !== em.en || wb.wr_tag_v_o !== em.en ||
          (em.en && (wb.addra_o !== em.a || wb.dina_o !== em.d || wb.wr_tag_o !== em.a))) begin
        bad++;
        $display("FAIL write: got ena=%b wea=%b tagv=%b addra=%0d dina=%h tag=%0d, want en=%b addr=%0d data=%h",
                 wb.ena_o, wb.wea_o, wb.wr_tag_v_o, wb.addra_o, wb.dina_o, wb.wr_tag_o,
                 em.en, em.a, em.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    wb.req_i = 4'hF;
    for (int i = 0; i < NREQ; i++) begin
      wb.addr_i[i] = AW'(i + 1);
      wb.data_i[i] = WID'(32'h155 + i);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (wb.ena_o !== 1'b0 || wb.wea_o !== 1'b0 || wb.addra_o !== '0 || wb.dina_o !== '0 ||
        wb.wr_tag_o !== '0 || wb.wr_tag_v_o !== 1'b0 || wb.init_done_o !== 1'b0 || wb.ack_o !== 4'b0) begin
      bad++;
      $display("FAIL reset_vals: ena=%b wea=%b addra=%0d dina=%h tag=%0d tagv=%b done=%b ack=%b, want all 0",
               wb.ena_o, wb.wea_o, wb.addra_o, wb.dina_o, wb.wr_tag_o, wb.wr_tag_v_o, wb.init_done_o, wb.ack_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= DEP; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (wb.ena_o !== 1'b1 || wb.wea_o !== 1'b1 || wb.addra_o !== AW'(k - 1) || wb.dina_o !== '0 ||
          wb.wr_tag_v_o !== 1'b0 || wb.init_done_o !== (k == DEP)) begin
        bad++;
        $display("FAIL fill_%0d: ena=%b wea=%b addra=%0d dina=%h tagv=%b done=%b, want 1 1 %0d 0 0 %b",
                 k, wb.ena_o, wb.wea_o, wb.addra_o, wb.dina_o, wb.wr_tag_v_o, wb.init_done_o,
                 k - 1, (k == DEP));
      end
      if (k < DEP) begin
        @(negedge clk);
        total++;
        if (wb.ack_o !== 4'b0) begin
          bad++;
          $display("FAIL init_ack_%0d: ack=%b want 0000", k, wb.ack_o);
        end
      end
    end
    wb.req_i = 4'b0;
    @(posedge clk);
    #1;
    total++;
    if (wb.ena_o !== 1'b0 || wb.init_done_o !== 1'b1) begin
      bad++;
      $display("FAIL fill_end: ena=%b done=%b want 0 1", wb.ena_o, wb.init_done_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ea;
    int w;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      wb.req_i = 4'hF;
      for (int i = 0; i < NREQ; i++) begin
        wb.addr_i[i] = AW'((i + c) % 7 + 1);
        wb.data_i[i] = WID'(32'h100 + c * 4 + i);
      end
      @(negedge clk);
      w  = c % 4;
      ea = 4'b0001 << w;
      total++;
      if (wb.ack_o !== ea) begin
        bad++;
        $display("FAIL rr_%0d: ack=%b want %b", c, wb.ack_o, ea);
      end
      sb.push_back('{en: 1'b1, a: wb.addr_i[w], d: wb.data_i[w]});
    end
    @(posedge clk);
    #1;
    wb.req_i = 4'b0;
    @(negedge clk);
    total++;
    if (wb.ack_o !== 4'b0) begin
      bad++;
      $display("FAIL idle_ack: ack=%b want 0000", wb.ack_o);
    end
    sb.push_back('{en: 1'b0, a: '0, d: '0});
  endtask

  task automatic test_ptr_wrap();
    logic [3:0] reqs [5];
    logic [3:0] acks [5];
    reqs = '{4'b0001, 4'b0010, 4'b0011, 4'b0010, 4'b0101};
    acks = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      wb.req_i = reqs[c];
      for (int i = 0; i < NREQ; i++) begin
        wb.addr_i[i] = AW'(i + 2);
        wb.data_i[i] = WID'(32'h2000 + c * 16 + i);
      end
      if (c == 1) begin
        wb.addr_i[1] = AW'(5);
        wb.data_i[1] = WID'(32'h1234);
      end
      @(negedge clk);
      total++;
      if (wb.ack_o !== acks[c]) begin
        bad++;
        $display("FAIL ptr_wrap_%0d: ack=%b want %b", c, wb.ack_o, acks[c]);
      end
      for (int i = 0; i < NREQ; i++)
        if (acks[c][i]) sb.push_back('{en: 1'b1, a: wb.addr_i[i], d: wb.data_i[i]});
    end
  endtask

  task automatic test_addr_zero();
    @(posedge clk);
    #1;
    wb.req_i     = 4'b1000;
    wb.addr_i[3] = '0;
    wb.data_i[3] = WID'(32'h1FFFF);
    @(negedge clk);
    total++;
    if (wb.ack_o !== 4'b1000) begin
      bad++;
      $display("FAIL addr0_ack: ack=%b want 1000", wb.ack_o);
    end
    sb.push_back('{en: 1'b0, a: '0, d: '0});
    @(posedge clk);
    #1;
    wb.req_i = 4'b0;
    @(negedge clk);
    sb.push_back('{en: 1'b0, a: '0, d: '0});
  endtask

  task automatic test_random();
    logic [3:0] pend;
    logic [3:0] nw;
    logic [3:0] ea;
    int ptr_m;
    int w;
    int idx;
    int waitc [NREQ];
    pend  = '0;
    ptr_m = 0;
    for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      nw = 4'($urandom_range(0, 15)) & ~pend;
      for (int i = 0; i < NREQ; i++) begin
        if (nw[i]) begin
          wb.addr_i[i] = AW'($urandom_range(0, 7));
          wb.data_i[i] = WID'($urandom);
        end
      end
      pend     = pend | nw;
      wb.req_i = pend;
      @(negedge clk);
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (ptr_m + k) % NREQ;
        if (w < 0 && pend[idx]) w = idx;
      end
      ea = (w < 0) ? 4'b0 : (4'b0001 << w);
      total++;
      if (wb.ack_o !== ea) begin
        bad++;
        $display("FAIL rand_%0d: ack=%b want %b (req=%b)", c, wb.ack_o, ea, pend);
      end
      if (w >= 0) begin
        sb.push_back('{en: (wb.addr_i[w] != '0), a: wb.addr_i[w], d: wb.data_i[w]});
        pend[w]  = 1'b0;
        waitc[w] = 0;
        ptr_m    = (w + 1) % NREQ;
      end else begin
        sb.push_back('{en: 1'b0, a: '0, d: '0});
      end
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          waitc[i]++;
          total++;
          if (waitc[i] >= NREQ) begin
            bad++;
            $display("FAIL fairness_%0d: requester waited %0d cycles, want < %0d", i, waitc[i], NREQ);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    wb.req_i     = 4'b0100;
    wb.addr_i[2] = AW'(6);
    wb.data_i[2] = WID'(32'hABCD);
    @(negedge clk);
    total++;
    if (wb.ack_o !== 4'b0100) begin
      bad++;
      $display("FAIL mid_ack: ack=%b want 0100", wb.ack_o);
    end
    rst      = 1'b1;
    wb.req_i = 4'b0;
    @(posedge clk);
    #1;
    total++;
    if (wb.ena_o !== 1'b0 || wb.wr_tag_v_o !== 1'b0 || wb.addra_o !== '0 || wb.init_done_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst: ena=%b tagv=%b addra=%0d done=%b want 0 0 0 0",
               wb.ena_o, wb.wr_tag_v_o, wb.addra_o, wb.init_done_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (wb.ena_o !== 1'b1 || wb.addra_o !== AW'(k - 1) || wb.dina_o !== '0 || wb.init_done_o !== 1'b0) begin
        bad++;
        $display("FAIL refill_%0d: ena=%b addra=%0d dina=%h done=%b want 1 %0d 0 0",
                 k, wb.ena_o, wb.addra_o, wb.dina_o, wb.init_done_o, k - 1);
      end
    end
  endtask

  initial begin
    wb.req_i  = '0;
    wb.addr_i = '0;
    wb.data_i = '0;
    test_reset();
    test_round_robin();
    test_ptr_wrap();
    test_addr_zero();
    test_random();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected writes never observed, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qupls_regfile_write_arbiter.md
# qupls_regfile_write_arbiter

Shares the single write port of one physical register file RAM bank among `NREQ` result buses (ALUs, FPU, load unit), using round-robin arbitration. After reset it sequences a zero-fill of every physical register before any write is granted. It broadcasts the written register tag for wakeup logic. It sits between the functional-unit writeback buses and the register file RAM's port A (`ena`/`wea`/`addra`/`dina`).

## Interface
Parameters:
- `NREQ`, 4: number of writeback requesters.
- `WID`, `$bits(cpu_types_pkg::value_t)+1`: write data width, value plus tag/valid bit.
- `DEP`, `QuplsPkg::PREGS`: number of physical registers.
- `RBIT`, local, `$clog2(DEP)-1`: address MSB.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req_i`, in, `NREQ`: per-requester write request; held until acked.
- `addr_i`, in, `NREQ` x `[RBIT:0]`: destination physical register per requester.
- `data_i`, in, `NREQ` x `WID`: write data per requester.
- `ack_o`, out, `NREQ`: one-hot grant; combinational, same cycle as win.
- `ena_o`, out, 1: RAM port A enable (registered).
- `wea_o`, out, 1: RAM port A write enable (registered).
- `addra_o`, out, `[RBIT:0]`: RAM write address (registered).
- `dina_o`, out, `WID`: RAM write data (registered).
- `wr_tag_o`, out, `[RBIT:0]`: register written this cycle, for wakeup.
- `wr_tag_v_o`, out, 1: `wr_tag_o` valid.
- `init_done_o`, out, 1: zero-fill complete; arbitration active.

## Operation
- States: `INIT` and `RUN`. Reset enters `INIT` with fill counter 0 and round-robin pointer 0.
- Reset values: all outputs are 0, and `ack_o` is 0.
- `INIT`:
  - Each cycle, register `ena_o`=`wea_o`=1, `addra_o`=counter, `dina_o`=0. Then increment the counter.
  - `ack_o` is held at 0 and requests are ignored.
  - `wr_tag_v_o` stays 0 during `INIT`.
  - When the counter equals `DEP-1` and is written, go to `RUN`. The counter does not wrap.
- `RUN`:
  - The winner is the first asserted `req_i` at or after the pointer, searching upward modulo `NREQ`. `ack_o[winner]`=1.
  - On a grant, the pointer becomes (winner+1) mod `NREQ`. With no request, the pointer holds.
  - At the next edge, register `ena_o`=`wea_o`=1, `addra_o`=`addr_i[winner]`, `dina_o`=`data_i[winner]`, `wr_tag_o`=the same address, `wr_tag_v_o`=1.
  - With no grant, register `ena_o`=`wea_o`=`wr_tag_v_o`=0. Address and data hold.
  - Address 0 is hardwired zero. A grant to `addr_i`=0 is acked, but `ena_o`, `wea_o` and `wr_tag_v_o` register as 0.
- Fairness: a continuously asserted requester is granted within `NREQ` cycles.
- Two requesters targeting the same address in consecutive cycles are both written in grant order. The last grant wins in the RAM. The arbiter does not check for this.
- `rst` mid-operation: `rst` returns the block to `INIT` immediately. Any in-flight registered write is dropped and the zero-fill restarts at address 0.

## Timing
- Grant-to-write latency is one cycle. `ack_o` is asserted in cycle N, and `ena_o` with the write data is asserted in cycle N+1. The RAM captures the write at the end of cycle N+1.
- Handshake: the requester drops or changes `req_i` after the edge that ends its `ack_o` cycle. `ack_o` is never asserted without the corresponding `req_i`.
- Zero-fill timing:
  - Edge k (k=1..`DEP`) after `rst` deasserts loads `addra_o`=k-1.
  - `init_done_o` rises after edge `DEP`.
  - The first grant is possible in the cycle after edge `DEP`, and the first arbitrated write appears after edge `DEP`+1.
- Throughput: one write per cycle in `RUN`, with no bubbles between back-to-back grants.

## Test plan
- Reset, `DEP`=8: `ena_o` is high for exactly 8 cycles with `addra_o`=0..7 and `dina_o`=0. `init_done_o`=1 after edge 8. `req_i` held at 4'b1111 gets no ack during `INIT`.
- `RUN`, pointer 0, `req_i`=4'b1111 held for 8 cycles: the grant sequence is 0,1,2,3,0,1,2,3. `addra_o` follows `addr_i` of each winner one cycle later.
- `RUN`, pointer 2, `req_i`=4'b0011: requester 0 is granted, then 1. The pointer ends at 2.
- Requester 1 writes addr 5, data 'h1234: `ack_o`=4'b0010. The next cycle has `ena_o`=`wea_o`=1, `addra_o`=5, `dina_o`='h1234, `wr_tag_o`=5, `wr_tag_v_o`=1.
- Requester 3 writes addr 0: `ack_o[3]`=1. The next cycle has `ena_o`=0 and `wr_tag_v_o`=0.
- Assert `rst` one cycle after a grant: no write appears. The output is 0 during reset, then the zero-fill restarts at addr 0 with `init_done_o`=0.
